plic_scan_ctrl: RTL and testbench

PLIC_SCAN_CTRL -- requirements
Module: plic_scan_ctrl

---
 rtl/plic_scan_ctrl_if.sv | 36 +++
 rtl/plic_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_plic_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : plic_scan_ctrl_if
// Brief    : Gateway/config inputs and per-target best-interrupt outputs
//            exchanged with the PLIC priority scanner.
// Revision : 1.0
// ============================================================================
interface plic_scan_ctrl_if #(
    parameter int SRC_N  = 1,
    parameter int TGT_N  = 1,
    parameter int PRIO_W = 1
);
    logic [SRC_N:0]                  int_pending;
    logic [(SRC_N+1)*PRIO_W-1:0]     cfg_int_prio;
    logic [TGT_N*(SRC_N+1)-1:0]      cfg_int_enable;
    logic                            rescan;
    logic                            claim_valid;
    logic [4:0]                      claim_tgt;
    logic [TGT_N*PRIO_W-1:0]         max_prio;
    logic [TGT_N*5-1:0]              max_src;
    logic                            scan_done;
    logic                            busy;

    modport master (
        output int_pending, cfg_int_prio, cfg_int_enable,
        output rescan, claim_valid, claim_tgt,
        input  max_prio, max_src, scan_done, busy
    );

    modport slave (
        input  int_pending, cfg_int_prio, cfg_int_enable,
        input  rescan, claim_valid, claim_tgt,
        output max_prio, max_src, scan_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/plic_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : plic_scan_ctrl
// Brief    : Sequential PLIC priority scanner, one source per cycle for all
//            targets; optional idle-on-steady mode via PLIC_SCAN_IDLE_EN.
// Revision : 1.0
// ============================================================================
module plic_scan_ctrl #(
    parameter int SRC_N  = 1,
    parameter int TGT_N  = 1,
    parameter int PRIO_W = 1
) (
    input wire              clk,
    input wire              rst_n,
    plic_scan_ctrl_if.slave bus
);

    localparam int         c_SW       = SRC_N + 1;
    localparam logic [4:0] c_LAST_IDX = 5'(SRC_N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_idx;
    logic [PRIO_W-1:0]    r_run_prio [TGT_N];
    logic [4:0]           r_run_src  [TGT_N];
    logic [PRIO_W-1:0]    r_max_prio [TGT_N];
    logic [4:0]           r_max_src  [TGT_N];
    logic                 r_scan_done;

    logic                 w_restart;
    logic                 w_enter_scan;
    logic                 w_commit;
    logic                 w_cur_pend;
    logic [PRIO_W-1:0]    w_cur_prio;
    logic [TGT_N-1:0]     w_cur_en;
    logic [TGT_N-1:0]     w_take;
    logic [TGT_N-1:0]     w_clr;
    logic [TGT_N*PRIO_W-1:0] w_max_prio_flat;
    logic [TGT_N*5-1:0]      w_max_src_flat;
    logic                 w_unused;

`ifdef PLIC_SCAN_IDLE_EN
    logic [SRC_N:1]       r_snap;
    logic                 w_pend_chg;
    assign w_pend_chg = (bus.int_pending[SRC_N:1] != r_snap);
`endif

    assign w_restart = bus.claim_valid | bus.rescan;

    // Select the attributes of the source under evaluation; ID 0 is never scanned.
    always_comb begin
        w_cur_pend = 1'b0;
        w_cur_prio = '0;
        w_cur_en   = '0;
        for (int i = 1; i <= SRC_N; i++) begin
            if (r_idx == 5'(i)) begin
                w_cur_pend = bus.int_pending[i];
                w_cur_prio = bus.cfg_int_prio[i*PRIO_W +: PRIO_W];
                for (int t = 0; t < TGT_N; t++) begin
                    w_cur_en[t] = bus.cfg_int_enable[t*c_SW + i];
                end
            end
        end
    end

    always_comb begin
        w_unused = bus.int_pending[0] ^ (|bus.cfg_int_prio[PRIO_W-1:0]);
        for (int t = 0; t < TGT_N; t++) begin
            w_unused = w_unused ^ bus.cfg_int_enable[t*c_SW];
        end
    end

    generate
        for (genvar g = 0; g < TGT_N; g++) begin : g_tgt
            // Strictly greater keeps the earlier (lower) ID on a priority tie.
            assign w_take[g] = w_cur_pend & w_cur_en[g] & (|w_cur_prio)
                             & (w_cur_prio > r_run_prio[g]);
            assign w_clr[g]  = bus.claim_valid & (bus.claim_tgt == 5'(g));
            assign w_max_prio_flat[g*PRIO_W +: PRIO_W] = r_max_prio[g];
            assign w_max_src_flat[g*5 +: 5]            = r_max_src[g];
        end
    endgenerate

    assign bus.max_prio  = w_max_prio_flat;
    assign bus.max_src   = w_max_src_flat;
    assign bus.scan_done = r_scan_done;
    assign bus.busy      = (r_state == S_SCAN) || (r_state == S_COMMIT);

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_scan = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
`ifdef PLIC_SCAN_IDLE_EN
                w_state_nxt = S_IDLE;
`else
                w_state_nxt  = S_SCAN;
                w_enter_scan = 1'b1;
`endif
            end
            S_IDLE: begin
`ifdef PLIC_SCAN_IDLE_EN
                if (w_pend_chg) begin
                    w_state_nxt  = S_SCAN;
                    w_enter_scan = 1'b1;
                end
`else
                w_state_nxt  = S_SCAN;
                w_enter_scan = 1'b1;
`endif
            end
            default: begin
                w_state_nxt  = S_SCAN;
                w_enter_scan = 1'b1;
            end
        endcase
        // A claim or config write restarts the pass and suppresses any commit.
        if (w_restart) begin
            w_state_nxt  = S_SCAN;
            w_enter_scan = 1'b1;
            w_commit     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_SCAN;
            r_idx       <= 5'd1;
            r_scan_done <= 1'b0;
            for (int t = 0; t < TGT_N; t++) begin
                r_run_prio[t] <= '0;
                r_run_src[t]  <= '0;
                r_max_prio[t] <= '0;
                r_max_src[t]  <= '0;
            end
`ifdef PLIC_SCAN_IDLE_EN
            r_snap <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_scan_done <= w_commit;
            if (w_enter_scan) begin
                r_idx <= 5'd1;
            end else if ((r_state == S_SCAN) && (r_idx != c_LAST_IDX)) begin
                r_idx <= r_idx + 5'd1;
            end
            for (int t = 0; t < TGT_N; t++) begin
                if (w_enter_scan) begin
                    r_run_prio[t] <= '0;
                    r_run_src[t]  <= '0;
                end else if ((r_state == S_SCAN) && w_take[t]) begin
                    r_run_prio[t] <= w_cur_prio;
                    r_run_src[t]  <= r_idx;
                end
                if (w_commit) begin
                    r_max_prio[t] <= r_run_prio[t];
                    r_max_src[t]  <= r_run_src[t];
                end else if (w_clr[t]) begin
                    r_max_prio[t] <= '0;
                    r_max_src[t]  <= '0;
                end
            end
`ifdef PLIC_SCAN_IDLE_EN
            if (w_commit) begin
                r_snap <= bus.int_pending[SRC_N:1];
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plic_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_scan_ctrl
// Brief    : Directed bench for plic_scan_ctrl with a pass-level reference model.
// Revision : 1.0
// ============================================================================
module tb_plic_scan_ctrl;

    localparam int SRC_N  = 3;
    localparam int TGT_N  = 2;
    localparam int PRIO_W = 3;

    logic clk = 1'b0;
    logic rst_n;

    plic_scan_ctrl_if #(.SRC_N(SRC_N), .TGT_N(TGT_N), .PRIO_W(PRIO_W)) bus ();

    plic_scan_ctrl #(.SRC_N(SRC_N), .TGT_N(TGT_N), .PRIO_W(PRIO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int src_of(input int t);
        logic [TGT_N*5-1:0] v;
        v = bus.max_src;
        return int'(v[t*5 +: 5]);
    endfunction

    function automatic int prio_of(input int t);
        logic [TGT_N*PRIO_W-1:0] v;
        v = bus.max_prio;
        return int'(v[t*PRIO_W +: PRIO_W]);
    endfunction

    task automatic set_prio(input int p1, input int p2, input int p3);
        bus.cfg_int_prio = {3'(p3), 3'(p2), 3'(p1), 3'd0};
    endtask

    // Model: winner for a target is the lowest-ID source of highest nonzero priority.
    bit       m_valid = 1'b0;
    int       m_cnt;
    bit       m_idle;
    bit       m_done;
    bit [3:1] m_snap;
    int       m_prio [TGT_N];
    int       m_src  [TGT_N];

    task automatic best(input int t, output int p, output int s);
        logic [(SRC_N+1)*PRIO_W-1:0] pr;
        logic [TGT_N*(SRC_N+1)-1:0]  en;
        int                          pi;
        pr = bus.cfg_int_prio;
        en = bus.cfg_int_enable;
        p = 0;
        s = 0;
        for (int i = 1; i <= SRC_N; i++) begin
            pi = int'(pr[i*PRIO_W +: PRIO_W]);
            if (bus.int_pending[i] && en[t*(SRC_N+1)+i] && pi != 0 && pi > p) begin
                p = pi;
                s = i;
            end
        end
    endtask

    always @(posedge clk) begin
        int bp, bs;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_idle  = 1'b0;
            m_done  = 1'b0;
            for (int t = 0; t < TGT_N; t++) begin
                m_prio[t] = 0;
                m_src[t]  = 0;
            end
        end else if (m_valid) begin
            m_done = 1'b0;
            if (bus.claim_valid) begin
                if (int'(bus.claim_tgt) < TGT_N) begin
                    m_prio[int'(bus.claim_tgt)] = 0;
                    m_src[int'(bus.claim_tgt)]  = 0;
                end
                m_cnt  = 0;
                m_idle = 1'b0;
            end else if (bus.rescan) begin
                m_cnt  = 0;
                m_idle = 1'b0;
            end else if (m_idle) begin
                if (bus.int_pending[3:1] != m_snap) begin
                    m_cnt  = 0;
                    m_idle = 1'b0;
                end
            end else if (m_cnt == SRC_N) begin
                for (int t = 0; t < TGT_N; t++) begin
                    best(t, bp, bs);
                    m_prio[t] = bp;
                    m_src[t]  = bs;
                end
                m_done = 1'b1;
`ifdef PLIC_SCAN_IDLE_EN
                m_idle = 1'b1;
                m_snap = bus.int_pending[3:1];
`else
                m_cnt = 0;
`endif
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp scan_done", int'(bus.scan_done), int'(m_done));
            check("cmp busy", int'(bus.busy), int'(!m_idle));
            for (int t = 0; t < TGT_N; t++) begin
                check($sformatf("cmp max_prio[%0d]", t), prio_of(t), m_prio[t]);
                check($sformatf("cmp max_src[%0d]", t), src_of(t), m_src[t]);
            end
        end
    end

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (bus.scan_done !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        check({name, " scan_done within bound"}, int'(k < 20), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.rescan         = 1'b0;
        bus.claim_valid    = 1'b0;
        bus.claim_tgt      = 5'd0;
        bus.int_pending    = 4'b1111;
        set_prio(2, 5, 5);
        bus.cfg_int_enable = {4'b1000, 4'b1111};
        step(2);
        check("reset busy", int'(bus.busy), 1);
        check("reset scan_done", int'(bus.scan_done), 0);
        check("reset max_src[0]", src_of(0), 0);
        check("reset max_prio[0]", prio_of(0), 0);

        // Release: first pass result visible four cycles later.
        rst_n = 1'b1;
        step(3);
        check("first pass early scan_done", int'(bus.scan_done), 0);
        step(1);
        check("first pass scan_done", int'(bus.scan_done), 1);
        check("tie max_src[0]", src_of(0), 2);
        check("tie max_prio[0]", prio_of(0), 5);
        check("tgt1 max_src", src_of(1), 3);
        check("tgt1 max_prio", prio_of(1), 5);

        // Zero priority disqualifies a source.
        set_prio(2, 0, 5);
        bus.rescan = 1'b1;
        step(1);
        bus.rescan = 1'b0;
        wait_done("prio2 zero");
        check("prio2 zero max_src[0]", src_of(0), 3);
        check("prio2 zero max_prio[0]", prio_of(0), 5);

        set_prio(0, 0, 0);
        bus.rescan = 1'b1;
        step(1);
        bus.rescan = 1'b0;
        wait_done("all zero");
        check("all zero max_src[0]", src_of(0), 0);
        check("all zero max_prio[0]", prio_of(0), 0);
        check("all zero max_src[1]", src_of(1), 0);

        // Per-target enables; the highest priority source is enabled nowhere.
        set_prio(1, 6, 4);
        bus.cfg_int_enable = {4'b1000, 4'b0010};
        bus.rescan = 1'b1;
        step(1);
        bus.rescan = 1'b0;
        wait_done("two targets");
        check("two targets max_src[0]", src_of(0), 1);
        check("two targets max_prio[0]", prio_of(0), 1);
        check("two targets max_src[1]", src_of(1), 3);
        check("two targets max_prio[1]", prio_of(1), 4);

`ifndef PLIC_SCAN_IDLE_EN
        // Claim target 1 while in COMMIT.
        step(3);
        bus.claim_valid = 1'b1;
        bus.claim_tgt   = 5'd1;
        step(1);
        bus.claim_valid = 1'b0;
        check("claim commit max_src[1]", src_of(1), 0);
        check("claim commit max_prio[1]", prio_of(1), 0);
        check("claim commit scan_done", int'(bus.scan_done), 0);
        check("claim commit max_src[0]", src_of(0), 1);
        step(3);
        check("claim commit early scan_done", int'(bus.scan_done), 0);
        step(1);
        check("claim commit new scan_done", int'(bus.scan_done), 1);
        check("claim commit new max_src[1]", src_of(1), 3);
`else
        // Steady inputs leave the scanner idle; a pending edge wakes it.
        step(2);
        check("idle busy", int'(bus.busy), 0);
        bus.int_pending = bus.int_pending ^ 4'b0010;
        step(1);
        check("wake busy", int'(bus.busy), 1);
        step(3);
        check("wake early scan_done", int'(bus.scan_done), 0);
        step(1);
        check("wake scan_done", int'(bus.scan_done), 1);
        check("wake max_src[0]", src_of(0), 0);
        bus.int_pending = 4'b1111;
        bus.claim_valid = 1'b1;
        bus.claim_tgt   = 5'd1;
        step(1);
        bus.claim_valid = 1'b0;
        check("idle claim max_src[1]", src_of(1), 0);
        check("idle claim busy", int'(bus.busy), 1);
        wait_done("idle claim");
        check("idle claim new max_src[1]", src_of(1), 3);
`endif

        // Out-of-range claim restarts without clearing anything.
        step(1);
        bus.claim_valid = 1'b1;
        bus.claim_tgt   = 5'd5;
        step(1);
        bus.claim_valid = 1'b0;
        check("oor claim max_src[0]", src_of(0), 1);
        check("oor claim max_src[1]", src_of(1), 3);
        check("oor claim busy", int'(bus.busy), 1);

        // Claim and rescan together act as the claim.
        bus.claim_valid = 1'b1;
        bus.rescan      = 1'b1;
        bus.claim_tgt   = 5'd0;
        step(1);
        bus.claim_valid = 1'b0;
        bus.rescan      = 1'b0;
        check("claim+rescan max_src[0]", src_of(0), 0);
        check("claim+rescan max_src[1]", src_of(1), 3);
        wait_done("claim+rescan");
        check("claim+rescan new max_src[0]", src_of(0), 1);

        // Reset when idx=2 aborts the pass.
        bus.rescan = 1'b1;
        step(1);
        bus.rescan = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(1);
        check("mid reset max_src[0]", src_of(0), 0);
        check("mid reset max_src[1]", src_of(1), 0);
        check("mid reset scan_done", int'(bus.scan_done), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post reset no scan_done c%0d", k), int'(bus.scan_done), 0);
            step(1);
        end
        check("post reset scan_done", int'(bus.scan_done), 1);
        check("post reset max_src[1]", src_of(1), 3);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
